// File: rtl/viterbi_frame_ctrl.sv
// Viterbi decoder front-half sequencer: frame intake, slicer pacing,
// aligned BM/ACS enables, drain and traceback handoff.
`ifndef CODE_RATE_2
`define CODE_RATE_2 1'b0
`endif
`ifndef CODE_RATE_3
`define CODE_RATE_3 1'b1
`endif

module viterbi_frame_ctrl #(
    parameter int FRAME_W   = 16,
    parameter int SLICE_LAT = 1,
    parameter int BM_LAT    = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_start,
    input  logic               i_code_rate,
    input  logic               i_frame_valid,
    input  logic [FRAME_W-1:0] i_frame,
    input  logic               i_frame_last,
    output logic               o_frame_ready,
    output logic [FRAME_W-1:0] o_data_frame,
    output logic               o_code_rate,
    output logic               o_slice_clr,
    output logic               o_en_s,
    output logic               o_en_bm,
    output logic               o_en_acs,
    output logic               o_en_t,
    input  logic               i_t_done,
    output logic [15:0]        o_step_cnt,
    output logic               o_busy,
    output logic               o_done
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SLICE,
        FLUSH,
        TRACE,
        DONE
    } state_t;

    localparam logic [7:0] SPF2_M1 = 8'(FRAME_W / 4 - 1);
    localparam logic [7:0] SPF3_M1 = 8'(FRAME_W / 6 - 1);

    state_t               state;
    logic [7:0]           cnt;
    logic                 last_frame;
    logic [SLICE_LAT-1:0] s_pipe;
    logic [BM_LAT-1:0]    b_pipe;
    logic                 pipes_empty;

    assign o_en_bm     = s_pipe[SLICE_LAT-1];
    assign o_en_acs    = b_pipe[BM_LAT-1];
    assign pipes_empty = (s_pipe == '0) && (b_pipe == '0);

    // Delay lines aligning BM and ACS enables to their data; free-running.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s_pipe <= '0;
            b_pipe <= '0;
        end else begin
            s_pipe <= SLICE_LAT'({s_pipe, o_en_s});
            b_pipe <= BM_LAT'({b_pipe, o_en_bm});
        end
    end

    // Job sequencer with registered outputs and the ACS step counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            cnt           <= '0;
            last_frame    <= 1'b0;
            o_frame_ready <= 1'b0;
            o_data_frame  <= '0;
            o_code_rate   <= `CODE_RATE_2;
            o_slice_clr   <= 1'b0;
            o_en_s        <= 1'b0;
            o_en_t        <= 1'b0;
            o_step_cnt    <= '0;
            o_busy        <= 1'b0;
            o_done        <= 1'b0;
        end else begin
            o_slice_clr <= 1'b0;
            o_done      <= 1'b0;
            if (o_en_acs && (o_step_cnt != 16'hFFFF)) begin
                o_step_cnt <= o_step_cnt + 16'd1;
            end
            unique case (state)
                IDLE: begin
                    if (i_start) begin
                        o_code_rate   <= i_code_rate;
                        o_busy        <= 1'b1;
                        o_step_cnt    <= '0;
                        o_frame_ready <= 1'b1;
                        state         <= LOAD;
                    end
                end
                LOAD: begin
                    if (i_frame_valid && o_frame_ready) begin
                        o_data_frame  <= i_frame;
                        last_frame    <= i_frame_last;
                        o_slice_clr   <= 1'b1;
                        o_en_s        <= 1'b1;
                        o_frame_ready <= 1'b0;
                        cnt           <= (o_code_rate == `CODE_RATE_3)
                                         ? SPF3_M1 : SPF2_M1;
                        state         <= SLICE;
                    end
                end
                SLICE: begin
                    if (cnt == 8'd0) begin
                        o_en_s <= 1'b0;
                        if (last_frame) begin
                            state <= FLUSH;
                        end else begin
                            o_frame_ready <= 1'b1;
                            state         <= LOAD;
                        end
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                FLUSH: begin
                    if (pipes_empty) begin
                        o_en_t <= 1'b1;
                        state  <= TRACE;
                    end
                end
                TRACE: begin
                    if (i_t_done) begin
                        o_en_t <= 1'b0;
                        o_busy <= 1'b0;
                        o_done <= 1'b1;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_viterbi_frame_ctrl.sv
// Scoreboard bench for viterbi_frame_ctrl: randomized jobs, queued
// expectations from a transaction-level model, decoupled monitor.
module tb_viterbi_frame_ctrl;

    localparam int   FW = 16;
    localparam int   SL = 1;
    localparam int   BL = 1;
    localparam logic R2 = 1'b0;
    localparam logic R3 = 1'b1;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_start;
    logic          i_code_rate;
    logic          i_frame_valid;
    logic [FW-1:0] i_frame;
    logic          i_frame_last;
    logic          o_frame_ready;
    logic [FW-1:0] o_data_frame;
    logic          o_code_rate;
    logic          o_slice_clr;
    logic          o_en_s;
    logic          o_en_bm;
    logic          o_en_acs;
    logic          o_en_t;
    logic          i_t_done;
    logic [15:0]   o_step_cnt;
    logic          o_busy;
    logic          o_done;

    typedef struct {
        logic [15:0] data;
        logic        rate;
        int          spf;
    } frm_t;

    typedef struct {
        logic rate;
        int   steps;
    } job_t;

    frm_t fq[$];
    job_t jq[$];
    int   checks = 0;
    int   passes = 0;
    bit   mon_en = 1'b0;
    int   cyc = 0;

    always #5 clk = ~clk;

    viterbi_frame_ctrl #(
        .FRAME_W  (FW),
        .SLICE_LAT(SL),
        .BM_LAT   (BL)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .i_start      (i_start),
        .i_code_rate  (i_code_rate),
        .i_frame_valid(i_frame_valid),
        .i_frame      (i_frame),
        .i_frame_last (i_frame_last),
        .o_frame_ready(o_frame_ready),
        .o_data_frame (o_data_frame),
        .o_code_rate  (o_code_rate),
        .o_slice_clr  (o_slice_clr),
        .o_en_s       (o_en_s),
        .o_en_bm      (o_en_bm),
        .o_en_acs     (o_en_acs),
        .o_en_t       (o_en_t),
        .i_t_done     (i_t_done),
        .o_step_cnt   (o_step_cnt),
        .o_busy       (o_busy),
        .o_done       (o_done)
    );

    function automatic int spf_of(input logic r);
        return (r == R3) ? FW / 6 : FW / 4;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)",
                      name, act, exp, $time);
    endtask

    task automatic outs_zero(input string tag);
        chk({tag, " ready"}, 32'(o_frame_ready), 0);
        chk({tag, " data"}, 32'(o_data_frame), 0);
        chk({tag, " rate"}, 32'(o_code_rate), 32'(R2));
        chk({tag, " slice_clr"}, 32'(o_slice_clr), 0);
        chk({tag, " en_s"}, 32'(o_en_s), 0);
        chk({tag, " en_bm"}, 32'(o_en_bm), 0);
        chk({tag, " en_acs"}, 32'(o_en_acs), 0);
        chk({tag, " en_t"}, 32'(o_en_t), 0);
        chk({tag, " step"}, 32'(o_step_cnt), 0);
        chk({tag, " busy"}, 32'(o_busy), 0);
        chk({tag, " done"}, 32'(o_done), 0);
    endtask

    // Monitor: pops expectations whenever the DUT presents a frame or done.
    logic [7:0] hs, hb;
    bit   acc_prev, in_run, have_cur, have_job;
    bit   td_prev, start_prev, done_prev, ent_prev;
    frm_t cur;
    job_t cj;
    int   run_len, acs_cnt, last_acs_cyc;

    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (!mon_en) begin
                hs = '0; hb = '0;
                acc_prev = 0; in_run = 0; have_cur = 0; have_job = 0;
                td_prev = 0; start_prev = 0; done_prev = 0; ent_prev = 0;
                run_len = 0; acs_cnt = 0; last_acs_cyc = 0;
                continue;
            end
            if (start_prev) begin
                chk("busy after start", 32'(o_busy), 1);
                chk("ready after start", 32'(o_frame_ready), 1);
                chk("step cleared", 32'(o_step_cnt), 0);
                if (jq.size() == 0) begin
                    chk("job expected", 0, 1);
                end else begin
                    cj = jq.pop_front();
                    have_job = 1;
                end
                acs_cnt = 0;
            end
            if (have_job) chk("code_rate", 32'(o_code_rate), 32'(cj.rate));
            if (acc_prev) begin
                chk("slice_clr after accept", 32'(o_slice_clr), 1);
                chk("ready low after accept", 32'(o_frame_ready), 0);
                if (fq.size() == 0) begin
                    chk("frame expected", 0, 1);
                end else begin
                    cur = fq.pop_front();
                    have_cur = 1;
                end
                in_run = 1;
                run_len = 0;
            end else if (o_slice_clr) begin
                chk("spurious slice_clr", 32'(o_slice_clr), 0);
            end
            if (have_cur) chk("data_frame", 32'(o_data_frame), 32'(cur.data));
            if (in_run) begin
                if (o_en_s) begin
                    run_len++;
                end else begin
                    chk("en_s run length", 32'(run_len), 32'(cur.spf));
                    in_run = 0;
                end
            end else begin
                chk("en_s outside run", 32'(o_en_s), 0);
            end
            chk("en_bm delay", 32'(o_en_bm), 32'(hs[SL-1]));
            chk("en_acs delay", 32'(o_en_acs), 32'(hb[BL-1]));
            if (o_en_t && !ent_prev)
                chk("drain gap to en_t", 32'(cyc - last_acs_cyc), 2);
            if (o_en_acs) begin
                acs_cnt++;
                last_acs_cyc = cyc;
            end
            if (td_prev) begin
                chk("done pulse", 32'(o_done), 1);
                chk("en_t low at done", 32'(o_en_t), 0);
                chk("busy low at done", 32'(o_busy), 0);
                chk("step_cnt at done", 32'(o_step_cnt), 32'(cj.steps));
                chk("acs cycles", 32'(acs_cnt), 32'(cj.steps));
            end else if (o_done) begin
                chk("spurious done", 32'(o_done), 0);
            end
            if (done_prev) begin
                chk("step_cnt held", 32'(o_step_cnt), 32'(cj.steps));
                chk("busy after done", 32'(o_busy), 0);
            end
            done_prev  = td_prev;
            td_prev    = i_t_done && o_en_t;
            start_prev = i_start && !o_busy && !o_done;
            acc_prev   = i_frame_valid && o_frame_ready;
            ent_prev   = o_en_t;
            hs = {hs[6:0], o_en_s};
            hb = {hb[6:0], o_en_bm};
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic rate, input logic [15:0] d,
                              input logic lst);
        frm_t f;
        int   t;
        f.data = d;
        f.rate = rate;
        f.spf  = spf_of(rate);
        fq.push_back(f);
        i_frame       = d;
        i_frame_last  = lst;
        i_frame_valid = 1'b1;
        t = 0;
        while (!o_frame_ready && t < 100) begin
            tick();
            t++;
        end
        if (!o_frame_ready) chk("accept timeout", 0, 1);
        tick();
        i_frame_valid = 1'b0;
        i_frame       = 16'($urandom);
        i_frame_last  = 1'($urandom_range(0, 1));
    endtask

    task automatic run_job(input logic rate, input int nfr, input int gap,
                           input bit fix0, input logic [15:0] d0,
                           input bit poke_start, input bit poke_td);
        job_t j;
        int   t;
        int   g;
        j.rate  = rate;
        j.steps = nfr * spf_of(rate);
        jq.push_back(j);
        tick();
        i_start     = 1'b1;
        i_code_rate = rate;
        tick();
        i_start     = 1'b0;
        i_code_rate = 1'($urandom_range(0, 1));
        for (int k = 0; k < nfr; k++) begin
            g = (gap < 0) ? $urandom_range(0, 5) : gap;
            repeat (g) tick();
            if (poke_td && k == 1) begin
                t = 0;
                while (!o_frame_ready && t < 50) begin
                    tick();
                    t++;
                end
                i_t_done = 1'b1;
                tick();
                i_t_done = 1'b0;
            end
            send_frame(rate, (fix0 && k == 0) ? d0 : 16'($urandom),
                       (k == nfr - 1));
            if (poke_start && k == 0) begin
                i_start     = 1'b1;
                i_code_rate = ~rate;
                tick();
                i_start = 1'b0;
            end
        end
        t = 0;
        while (!o_en_t && t < 100) begin
            tick();
            t++;
        end
        if (!o_en_t) chk("en_t timeout", 0, 1);
        repeat (5) tick();
        i_t_done = 1'b1;
        tick();
        i_t_done = 1'b0;
        t = 0;
        while (!o_done && t < 20) begin
            tick();
            t++;
        end
        if (!o_done) chk("done timeout", 0, 1);
        repeat (3) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        job_t j;
        rst           = 1'b0;
        i_start       = 1'b0;
        i_code_rate   = R2;
        i_frame_valid = 1'b0;
        i_frame       = '0;
        i_frame_last  = 1'b0;
        i_t_done      = 1'b0;
        repeat (3) tick();
        outs_zero("reset");
        rst    = 1'b1;
        mon_en = 1'b1;

        run_job(R2, 1, 0, 1, 16'hA5C3, 0, 0);
        run_job(R3, 2, 0, 0, 16'h0, 0, 0);
        run_job(R2, 3, 0, 0, 16'h0, 0, 0);
        run_job(R2, 2, 6, 0, 16'h0, 0, 0);
        run_job(R2, 3, 0, 0, 16'h0, 1, 1);
        for (int n = 0; n < 8; n++) begin
            run_job(1'($urandom_range(0, 1)), $urandom_range(1, 4), -1,
                    0, 16'h0, 0, 0);
        end

        j.rate  = R2;
        j.steps = 8;
        jq.push_back(j);
        tick();
        i_start     = 1'b1;
        i_code_rate = R2;
        tick();
        i_start = 1'b0;
        send_frame(R2, 16'h1234, 1'b0);
        tick();
        tick();
        mon_en = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        outs_zero("async reset");
        tick();
        tick();
        outs_zero("held reset");
        rst = 1'b1;
        fq.delete();
        jq.delete();
        mon_en = 1'b1;
        repeat (3) tick();
        chk("idle after reset busy", 32'(o_busy), 0);
        chk("idle after reset ready", 32'(o_frame_ready), 0);

        run_job(R3, 2, -1, 0, 16'h0, 0, 0);
        run_job(R2, 2, -1, 0, 16'h0, 0, 0);
        repeat (5) tick();
        chk("frames left", 32'(fq.size()), 0);
        chk("jobs left", 32'(jq.size()), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/viterbi_frame_ctrl.md
Name: viterbi_frame_ctrl

Overview:
- Sequences the front half of the Viterbi decoder for one decode job.
- Accepts 16-bit data frames from the PS-side source over a valid/ready handshake and holds each frame for the slicer.
- Drives the slicer enable for exactly the number of cycles one frame needs at the latched code rate, then generates aligned enables for branch-metric and ACS.
- After the last frame and a pipeline drain, starts traceback and reports job completion.

Parameters:
- FRAME_W, 16, frame width in bits.
- SLICE_LAT, 1, cycles from o_en_s to valid slicer output (1..4).
- BM_LAT, 1, cycles from o_en_bm to valid branch metrics (1..4).

Ports:
- clk  in  1  clock.
- rst  in  1  reset; one clock, reset is asynchronous and active-low.
- i_start  in  1  one-cycle pulse; starts a job; honoured only in IDLE.
- i_code_rate  in  1  `CODE_RATE_2 or `CODE_RATE_3; sampled on an accepted i_start.
- i_frame_valid  in  1  source frame valid.
- i_frame  in  FRAME_W  frame data.
- i_frame_last  in  1  qualifies i_frame as the final frame of the job.
- o_frame_ready  out  1  controller can accept a frame.
- o_data_frame  out  FRAME_W  held frame to the slicer.
- o_code_rate  out  1  latched rate to the slicer, BM and ACS.
- o_slice_clr  out  1  one-cycle pulse; reloads the slicer bit pointer to FRAME_W-1.
- o_en_s  out  1  slicer enable.
- o_en_bm  out  1  branch-metric enable.
- o_en_acs  out  1  ACS enable.
- o_en_t  out  1  traceback enable.
- i_t_done  in  1  traceback finished.
- o_step_cnt  out  16  count of ACS-enabled cycles in the job.
- o_busy  out  1  job in progress.
- o_done  out  1  one-cycle pulse at job end.

Behaviour:
- Reset values:
  - All outputs 0.
  - o_data_frame 0.
  - o_code_rate `CODE_RATE_2.
  - FSM in IDLE.
  - Delay pipes cleared.
- Reset asserted mid-job aborts immediately; there is no drain and no o_done.
- All outputs are registered.
- SPF (slice cycles per frame) is FRAME_W/4 = 4 for `CODE_RATE_2 and FRAME_W/6 = 2 for `CODE_RATE_3. At rate 3 the 4 LSBs of each frame are discarded.
- FSM states:
  - IDLE: on i_start, latch o_code_rate, set o_busy=1, clear o_step_cnt, go to LOAD. i_start is ignored in every other state.
  - LOAD: o_frame_ready=1.
    - On valid&ready at the clock edge: capture i_frame into o_data_frame and i_frame_last into the last flag, pulse o_slice_clr=1 for the next cycle, load the slice counter with SPF-1, go to SLICE.
    - o_frame_ready is 0 the cycle after acceptance.
    - With valid low, LOAD holds indefinitely with o_en_s=0.
  - SLICE: o_en_s=1 for exactly SPF consecutive cycles while the counter decrements to 0. The first SLICE cycle coincides with o_slice_clr=1. At counter 0: go to FLUSH if the last flag is set, else go to LOAD.
    - Consequence: there is at least one o_en_s=0 bubble between frames.
  - FLUSH: o_en_s=0. Wait until the o_en_bm and o_en_acs delay pipes are all zero, then go to TRACE.
  - TRACE: o_en_t=1, held until i_t_done=1 is sampled; then o_en_t=0 and go to DONE. An i_t_done seen outside TRACE is ignored.
  - DONE: o_done=1 for one cycle and o_busy=0 in that same cycle; go to IDLE.
- Enable pipeline:
  - o_en_bm equals o_en_s delayed SLICE_LAT cycles.
  - o_en_acs equals o_en_bm delayed BM_LAT cycles.
  - Shift registers run in every state, so the enables keep draining during LOAD and FLUSH.
- o_step_cnt increments by 1 on each cycle o_en_acs=1. It saturates at 16'hFFFF and holds its value after DONE until the next accepted i_start.
- o_data_frame and o_code_rate are stable throughout SLICE and change only on frame acceptance or job start.

Test Plan:
- Rate 2, one frame 16'hA5C3 with last=1, SLICE_LAT=BM_LAT=1, i_t_done driven 5 cycles after o_en_t rises -> o_slice_clr and o_en_s rise on the same cycle; o_en_s high 4 cycles, o_en_bm high 4 cycles starting 1 later, o_en_acs high 4 cycles starting 2 later; o_en_t rises after the drain; o_step_cnt=4; one o_done pulse; o_busy=0 from that cycle.
- Rate 3, two frames (second last=1), valid held high -> o_en_s pattern 2 on, 1 off, 2 on; o_step_cnt=4; o_code_rate=`CODE_RATE_3 throughout.
- Rate 2, three back-to-back frames -> o_en_s pattern 4 on/1 off repeated; o_frame_ready high exactly one cycle per accepted frame; o_step_cnt=12.
- Valid stalled 6 cycles between frames -> o_en_s 0 during the stall; bm/acs enables drain on schedule; o_data_frame unchanged until the next acceptance.
- i_start pulsed during SLICE, and i_t_done pulsed during LOAD -> both ignored; the job completes normally with a single o_done.
- rst driven low during the 3rd SLICE cycle -> all outputs 0 asynchronously; after release, a new i_start runs a clean job.
